// File: rtl/thermo_pool_stream.sv
// Rank-order pooling of N thermometer words into one binary result.
// Optional THERMO_POOL_BUBBLE_CHK_EN flags malformed words on out_err.
module thermo_pool_stream #(
   parameter  int W  = 15,
   parameter  int N  = 4,
   localparam int OW = $clog2(W+1),
   localparam int CW = $clog2(N+1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic [CW-1:0] k_sel,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_data,
   output logic          out_err
);

   typedef enum logic [1:0] {
      ACCUM,
      REDUCE,
      HOLD
   } state_t;

   localparam logic [CW-1:0] NMAX  = CW'(N);
   localparam logic [CW-1:0] NLAST = CW'(N-1);

   state_t        state;
   state_t        state_n;
   logic [CW-1:0] cnt [W];
   logic [CW-1:0] bcnt;
   logic [CW-1:0] k_reg;
   logic [OW-1:0] pool;
   logic          acc;
   logic          hand;
   logic          last;

   assign last = (bcnt == NLAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ACCUM;
      else        state <= state_n;
   end

   // flush overrides both handshakes, so acc/hand are gated here
   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      acc       = 1'b0;
      hand      = 1'b0;
      unique case (state)
         ACCUM: begin
            in_ready = 1'b1;
            acc      = in_valid;
            if (acc && last) state_n = REDUCE;
         end
         REDUCE: state_n = HOLD;
         HOLD: begin
            out_valid = 1'b1;
            hand      = out_ready;
            if (hand) state_n = ACCUM;
         end
         default: state_n = ACCUM;
      endcase
      if (flush) begin
         state_n = ACCUM;
         acc     = 1'b0;
         hand    = 1'b0;
      end
   end

   always_comb begin
      pool = '0;
      for (int i = 0; i < W; i++) begin
         if (cnt[i] >= k_reg) pool = pool + OW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < W; i++) cnt[i] <= '0;
         bcnt  <= '0;
         k_reg <= '0;
      end else if (flush || hand) begin
         for (int i = 0; i < W; i++) cnt[i] <= '0;
         bcnt <= '0;
      end else if (acc) begin
         for (int i = 0; i < W; i++) begin
            if (in_data[i] && cnt[i] != NMAX)
               cnt[i] <= cnt[i] + CW'(1);
         end
         bcnt <= last ? '0 : bcnt + CW'(1);
         if (bcnt == '0) k_reg <= k_sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           out_data <= '0;
      else if (!flush && state == REDUCE)   out_data <= pool;
   end

`ifdef THERMO_POOL_BUBBLE_CHK_EN
   logic bubble;
   logic err_win;
   logic err_q;

   // a set bit above a clear bit breaks the thermometer code
   always_comb begin
      bubble = 1'b0;
      for (int i = 1; i < W; i++) begin
         if (in_data[i] && !in_data[i-1]) bubble = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_win <= 1'b0;
         err_q   <= 1'b0;
      end else if (flush || hand) begin
         err_win <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (acc && bubble)     err_win <= 1'b1;
         if (state == REDUCE)   err_q   <= err_win;
      end
   end

   assign out_err = err_q;
`else
   assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_thermo_pool_stream.sv
// Scoreboard bench for thermo_pool_stream at W=15, N=4.
module tb_thermo_pool_stream;

   localparam int W = 15;
   localparam int N = 4;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic [2:0]    k_sel;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [3:0]    out_data;
   logic          out_err;

   int         checks   = 0;
   int         failures = 0;
   logic [4:0] sb [$];
   logic [4:0] exp_r;

   thermo_pool_stream #(.W(W), .N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .k_sel     (k_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] th(input int c);
      th = W'((32'd1 << c) - 1);
   endfunction

   function automatic int kth(input int a, input int b,
                              input int c, input int d,
                              input int k);
      int v [4];
      int t;
      v = '{a, b, c, d};
      for (int i = 0; i < 4; i++)
         for (int j = i + 1; j < 4; j++)
            if (v[j] > v[i]) begin
               t = v[i]; v[i] = v[j]; v[j] = t;
            end
      if (k == 0) return W;
      if (k > N)  return 0;
      return v[k-1];
   endfunction

   // scoreboard: compare every handoff against the oldest expectation
   always @(negedge clk) begin
      if (rst_n && !flush && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected got=%0d want=none", out_data);
         end else begin
            exp_r = sb.pop_front();
            if (out_data !== exp_r[3:0]) begin
               failures++;
               $display("FAIL sb_data got=%0d want=%0d",
                        out_data, exp_r[3:0]);
            end
            checks++;
            if (out_err !== exp_r[4]) begin
               failures++;
               $display("FAIL sb_err got=%0b want=%0b",
                        out_err, exp_r[4]);
            end
         end
      end
   end

   task automatic send_word(input logic [W-1:0] w);
      int n;
      in_valid = 1'b1;
      in_data  = w;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         checks++; failures++;
         $display("FAIL ready_timeout got=0 want=1");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_window(input int a, input int b,
                              input int c, input int d,
                              input int k, input logic e);
      k_sel = 3'(k);
      sb.push_back({e, 4'(kth(a, b, c, d, k))});
      send_word(th(a));
      send_word(th(b));
      send_word(th(c));
      send_word(th(d));
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() != 0) begin
         checks++; failures++;
         $display("FAIL drain_timeout got=%0d want=0", sb.size());
      end
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!out_valid) begin
         checks++; failures++;
         $display("FAIL valid_timeout got=0 want=1");
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_ready got=%b want=1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_valid got=%b want=0", out_valid);
      end
      checks++;
      if (out_data !== 4'd0) begin
         failures++;
         $display("FAIL rst_data got=%0d want=0", out_data);
      end
      checks++;
      if (out_err !== 1'b0) begin
         failures++;
         $display("FAIL rst_err got=%b want=0", out_err);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_rel_ready got=%b want=1", in_ready);
      end
   endtask

   task automatic test_rank();
      send_window(1, 2, 4, 3, 2, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL lat_edge1 got=%b want=0", out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL lat_edge2 got=%b want=1", out_valid);
      end
      wait_drain();
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL rank_ready got=%b want=1", in_ready);
      end
   endtask

   task automatic test_k_select();
      int ks [4];
      ks = '{1, 4, 0, 5};
      for (int i = 0; i < 4; i++) begin
         send_window(9, 2, 0, 13, ks[i], 1'b0);
         wait_drain();
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      send_window(5, 6, 7, 8, 3, 1'b0);
      wait_valid();
      in_valid = 1'b1;
      in_data  = th(1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_data !== 4'd6) begin
            failures++;
            $display("FAIL bp_data cyc=%0d got=%0d want=6", i, out_data);
         end
         checks++;
         if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready cyc=%0d got=%b want=0", i, in_ready);
         end
         checks++;
         if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_valid cyc=%0d got=%b want=1", i, out_valid);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release got=%b want=1", in_ready);
      end
      wait_drain();
   endtask

   task automatic test_flush();
      k_sel = 3'd2;
      send_word(th(7));
      send_word(th(7));
      in_valid = 1'b1;
      in_data  = th(5);
      flush    = 1'b1;
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_state got=%b%b want=10",
                  in_ready, out_valid);
      end
      send_window(15, 15, 15, 15, 2, 1'b0);
      wait_drain();
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      send_window(9, 9, 9, 9, 1, 1'b0);
      wait_valid();
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL arst_valid got=%b want=0", out_valid);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL arst_ready got=%b want=1", in_ready);
      end
      checks++;
      if (out_data !== 4'd0) begin
         failures++;
         $display("FAIL arst_data got=%0d want=0", out_data);
      end
      sb.delete();
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      send_window(8, 8, 3, 0, 2, 1'b0);
      wait_drain();
   endtask

   task automatic test_bubble();
      logic e;
`ifdef THERMO_POOL_BUBBLE_CHK_EN
      e = 1'b1;
`else
      e = 1'b0;
`endif
      k_sel = 3'd2;
      sb.push_back({e, 4'd3});
      send_word(th(5));
      send_word(15'b000000000000101);
      send_word(th(3));
      send_word(th(1));
      wait_drain();
      send_window(2, 2, 2, 2, 2, 1'b0);
      wait_drain();
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      k_sel     = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      test_reset();
      test_rank();
      test_k_select();
      test_backpressure();
      test_flush();
      test_async_reset();
      test_bubble();
      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
